apb_dual_master_arbiter: RTL and testbench

//  Arbitrates two APB masters onto one shared APB bus: s0 is the core peripheral port, s1 the CNN

---
 rtl/apb_dual_master_arbiter.sv | 126 ++++++++++++
 tb/tb_apb_dual_master_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_dual_master_arbiter.sv
// Two-master APB arbiter: round-robin grant onto one shared APB bus, registered
// SETUP/ACCESS sequencing, PREADY wait states and an ACCESS-phase timeout reported as PSLVERR.
module apb_dual_master_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              s0_psel,
    input  logic              s0_penable,
    input  logic              s0_pwrite,
    input  logic [ADDR_W-1:0] s0_paddr,
    input  logic [31:0]       s0_pwdata,
    output logic [31:0]       s0_prdata,
    output logic              s0_pready,
    output logic              s0_pslverr,
    input  logic              s1_psel,
    input  logic              s1_penable,
    input  logic              s1_pwrite,
    input  logic [ADDR_W-1:0] s1_paddr,
    input  logic [31:0]       s1_pwdata,
    output logic [31:0]       s1_prdata,
    output logic              s1_pready,
    output logic              s1_pslverr,
    output logic              m_psel,
    output logic              m_penable,
    output logic              m_pwrite,
    output logic [ADDR_W-1:0] m_paddr,
    output logic [31:0]       m_pwdata,
    input  logic [31:0]       m_prdata,
    input  logic              m_pready,
    input  logic              m_pslverr,
    output logic              grant_o,
    output logic              busy_o,
    output logic              timeout_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

    localparam bit              TOUT_EN   = (TIMEOUT_CYC != 0);
    localparam logic [15:0]     TOUT_LAST = TOUT_EN ? 16'(TIMEOUT_CYC - 1) : 16'd0;

    state_t      state;
    logic        rr_last;
    logic        grant_q;
    logic        busy_q;
    logic [15:0] tcnt;

    logic any_req;
    logic winner;
    logic in_access;
    logic tout_hit;
    logic complete;
    logic unused_penable;

    // Upstream PENABLE carries no information the arbiter needs.
    assign unused_penable = s0_penable ^ s1_penable;

    assign any_req   = s0_psel | s1_psel;
    assign winner    = (s0_psel & s1_psel) ? ~rr_last : s1_psel;
    assign in_access = (state == ACCESS);
    assign tout_hit  = TOUT_EN && (tcnt == TOUT_LAST);
    assign complete  = in_access && (m_pready || tout_hit);
    // A slave answering on the limit cycle takes precedence over the timeout.
    assign timeout_o = in_access && !m_pready && tout_hit;

    assign grant_o = grant_q;
    assign busy_o  = busy_q;

    assign s0_pready  = complete && !grant_q;
    assign s0_prdata  = (s0_pready && m_pready) ? m_prdata : 32'd0;
    assign s0_pslverr = s0_pready && (m_pready ? m_pslverr : 1'b1);

    assign s1_pready  = complete && grant_q;
    assign s1_prdata  = (s1_pready && m_pready) ? m_prdata : 32'd0;
    assign s1_pslverr = s1_pready && (m_pready ? m_pslverr : 1'b1);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            grant_q   <= 1'b0;
            busy_q    <= 1'b0;
            tcnt      <= 16'd0;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_paddr   <= '0;
            m_pwdata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    // The winner's request is sampled only here, so a waiting master may change it freely.
                    if (any_req) begin
                        state     <= SETUP;
                        grant_q   <= winner;
                        busy_q    <= 1'b1;
                        tcnt      <= 16'd0;
                        m_psel    <= 1'b1;
                        m_penable <= 1'b0;
                        m_pwrite  <= winner ? s1_pwrite : s0_pwrite;
                        m_paddr   <= winner ? s1_paddr  : s0_paddr;
                        m_pwdata  <= winner ? s1_pwdata : s0_pwdata;
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    m_penable <= 1'b1;
                end
                ACCESS: begin
                    if (complete) begin
                        state     <= IDLE;
                        busy_q    <= 1'b0;
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        rr_last   <= grant_q;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_dual_master_arbiter.sv
// Directed and randomized bench for apb_dual_master_arbiter with a transfer-level model:
// the expected winner, timing and responses are derived per transfer from the arbitration rules.
module tb_apb_dual_master_arbiter;

    localparam int TO = 4;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        s0_psel, s0_penable, s0_pwrite, s1_psel, s1_penable, s1_pwrite;
    logic [31:0] s0_paddr, s0_pwdata, s1_paddr, s1_pwdata;
    logic [31:0] s0_prdata, s1_prdata;
    logic        s0_pready, s0_pslverr, s1_pready, s1_pslverr;
    logic        m_psel, m_penable, m_pwrite;
    logic [31:0] m_paddr, m_pwdata, m_prdata;
    logic        m_pready, m_pslverr;
    logic        grant_o, busy_o, timeout_o;

    apb_dual_master_arbiter #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .s0_psel(s0_psel), .s0_penable(s0_penable), .s0_pwrite(s0_pwrite),
        .s0_paddr(s0_paddr), .s0_pwdata(s0_pwdata), .s0_prdata(s0_prdata),
        .s0_pready(s0_pready), .s0_pslverr(s0_pslverr),
        .s1_psel(s1_psel), .s1_penable(s1_penable), .s1_pwrite(s1_pwrite),
        .s1_paddr(s1_paddr), .s1_pwdata(s1_pwdata), .s1_prdata(s1_prdata),
        .s1_pready(s1_pready), .s1_pslverr(s1_pslverr),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
        .m_pready(m_pready), .m_pslverr(m_pslverr),
        .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 HCLK = ~HCLK;

    int          errors = 0;
    int          checks = 0;
    logic        r_v [2];
    logic        r_w [2];
    logic [31:0] r_a [2];
    logic [31:0] r_d [2];
    int          skip [2];
    bit          rr_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_req();
        s0_psel = r_v[0]; s0_penable = r_v[0]; s0_pwrite = r_w[0]; s0_paddr = r_a[0]; s0_pwdata = r_d[0];
        s1_psel = r_v[1]; s1_penable = r_v[1]; s1_pwrite = r_w[1]; s1_paddr = r_a[1]; s1_pwdata = r_d[1];
    endtask

    task automatic new_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        r_v[i] = 1'b1; r_w[i] = w; r_a[i] = a; r_d[i] = d;
    endtask

    task automatic chk_resp(input bit done, input int g, input bit rdy, input logic [31:0] rdata, input logic serr);
        bit e0, e1;
        e0 = done && (g == 0);
        e1 = done && (g == 1);
        chk("s0_pready", s0_pready, e0);
        chk("s0_prdata", s0_prdata, (e0 && rdy) ? rdata : 32'd0);
        chk("s0_pslverr", s0_pslverr, e0 ? (rdy ? serr : 1'b1) : 1'b0);
        chk("s1_pready", s1_pready, e1);
        chk("s1_prdata", s1_prdata, (e1 && rdy) ? rdata : 32'd0);
        chk("s1_pslverr", s1_pslverr, e1 ? (rdy ? serr : 1'b1) : 1'b0);
        chk("timeout_o", timeout_o, done && !rdy);
    endtask

    task automatic chk_all_zero(input string tag);
        logic [31:0] agg;
        agg = s0_prdata | s1_prdata | m_paddr | m_pwdata;
        chk({tag, "_data"}, agg, 32'd0);
        chk({tag, "_ctrl"}, {s0_pready, s0_pslverr, s1_pready, s1_pslverr, m_psel, m_penable,
                             m_pwrite, grant_o, busy_o, timeout_o}, 32'd0);
    endtask

    // One arbitration round starting in an IDLE cycle; abort_k >= 0 resets during that ACCESS cycle.
    task automatic run_transfer(input int waits, input logic [31:0] rdata, input logic serr,
                                input int abort_k, input bit mutate);
        int          g, og;
        bit          rdy, done;
        logic        ew;
        logic [31:0] ea, ed;
        g  = (r_v[0] && r_v[1]) ? (rr_m ? 0 : 1) : (r_v[1] ? 1 : 0);
        ew = r_w[g]; ea = r_a[g]; ed = r_d[g];

        @(posedge HCLK); #1;
        drive_req(); m_pready = 1'b0; m_prdata = $urandom; m_pslverr = 1'($urandom); #1;
        chk("idle_psel", m_psel, 1'b0);
        chk("idle_busy", busy_o, 1'b0);
        chk_resp(1'b0, g, 1'b0, 32'd0, 1'b0);

        @(posedge HCLK); #1;
        if (mutate && r_v[1-g]) r_a[1-g] = $urandom;
        drive_req(); #1;
        og = (grant_o === 1'b1) ? 1 : 0;
        chk("setup_psel", m_psel, 1'b1);
        chk("setup_penable", m_penable, 1'b0);
        chk("setup_busy", busy_o, 1'b1);
        chk("grant", grant_o, g);
        chk("m_paddr", m_paddr, ea);
        chk("m_pwrite", m_pwrite, ew);
        chk("m_pwdata", m_pwdata, ed);
        chk_resp(1'b0, g, 1'b0, 32'd0, 1'b0);

        for (int k = 0; k < TO; k++) begin
            @(posedge HCLK); #1;
            rdy = (k == waits);
            m_pready  = rdy;
            m_prdata  = rdy ? rdata : $urandom;
            m_pslverr = rdy ? serr : 1'($urandom);
            if (k == abort_k) begin
                HRESETn = 1'b0; #1;
                chk_all_zero("rst_async");
                r_v[0] = 1'b0; r_v[1] = 1'b0; drive_req(); m_pready = 1'b0;
                @(posedge HCLK); #1;
                chk_all_zero("rst_hold");
                @(negedge HCLK);
                HRESETn = 1'b1;
                rr_m = 1'b1; skip[0] = 0; skip[1] = 0;
                return;
            end
            #1;
            done = rdy || (k == TO - 1);
            chk("access_psel", m_psel, 1'b1);
            chk("access_penable", m_penable, 1'b1);
            chk("access_paddr", m_paddr, ea);
            chk_resp(done, g, rdy, rdata, serr);
            if (done) break;
        end

        if (r_v[1-og]) skip[1-og]++;
        skip[og] = 0;
        chk("no_starve", skip[1-og] <= 1, 1'b1);
        rr_m   = (g == 1);
        r_v[g] = 1'b0;
    endtask

    initial begin
        HRESETn = 1'b0;
        r_v[0] = 0; r_v[1] = 0; r_w[0] = 0; r_w[1] = 0;
        r_a[0] = 0; r_a[1] = 0; r_d[0] = 0; r_d[1] = 0;
        skip[0] = 0; skip[1] = 0; rr_m = 1'b1;
        drive_req(); m_pready = 1'b0; m_prdata = 32'd0; m_pslverr = 1'b0;
        repeat (2) @(posedge HCLK);
        #1 chk_all_zero("reset");
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Tie after reset: s0 first, then s1.
        new_req(0, 1'b1, 32'h1000_0000, 32'h0000_00A0);
        new_req(1, 1'b0, 32'h1000_0004, 32'h0000_00B1);
        run_transfer(0, 32'h0, 1'b0, -1, 1'b0);
        run_transfer(0, 32'hA5A5_0001, 1'b0, -1, 1'b0);

        // Single zero-wait write from s0.
        new_req(0, 1'b1, 32'h2000_0010, 32'hCAFE_F00D);
        run_transfer(0, 32'h0, 1'b0, -1, 1'b0);

        // Tie again: s1 now wins.
        new_req(0, 1'b0, 32'h3000_0000, 32'h0);
        new_req(1, 1'b1, 32'h3000_0100, 32'h5555_AAAA);
        run_transfer(1, 32'h0, 1'b0, -1, 1'b0);
        run_transfer(0, 32'h0BAD_BEEF, 1'b1, -1, 1'b0);

        // s1 read with 3 wait states while s0 waits; ready on the limit cycle beats the timeout.
        new_req(0, 1'b1, 32'h4000_0000, 32'h1111_2222);
        new_req(1, 1'b0, 32'h4000_0040, 32'h0);
        run_transfer(3, 32'h1234_5678, 1'b0, -1, 1'b1);
        run_transfer(0, 32'h0, 1'b0, -1, 1'b0);

        // Slave never ready: timeout.
        new_req(0, 1'b0, 32'h5000_0000, 32'h0);
        run_transfer(99, 32'hDEAD_DEAD, 1'b0, -1, 1'b0);

        // Reset during ACCESS, then a fresh s1 request.
        new_req(0, 1'b0, 32'h6000_0000, 32'h0);
        run_transfer(10, 32'h0, 1'b0, 1, 1'b0);
        new_req(1, 1'b1, 32'h6000_0008, 32'h7777_8888);
        run_transfer(2, 32'h0, 1'b0, -1, 1'b0);

        // Randomized overlapping traffic.
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 2; i++)
                if (!r_v[i] && $urandom_range(0, 1) == 1) new_req(i, 1'($urandom), $urandom, $urandom);
            if (!r_v[0] && !r_v[1]) begin
                int j;
                j = $urandom_range(0, 1);
                new_req(j, 1'($urandom), $urandom, $urandom);
            end
            run_transfer($urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)), -1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
